// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: round-robin grant between fetch (F) and load/store (D),
// latches the winning request into MAR/MDR and sequences a fixed-latency memory access.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              f_gnt,
    output logic              d_gnt,
    output logic              f_ack,
    output logic              d_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LATCH  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              last_srv, last_srv_nx;
    logic              pick_d;
    logic              f_gnt_nx, d_gnt_nx, f_ack_nx, d_ack_nx;
    logic              busy_nx, mem_en_nx, mem_rw_nx;
    logic [DATA_W-1:0] rdata_nx, mem_wdata_nx;
    logic [ADDR_W-1:0] mem_addr_nx;

    // State register plus registered copies of every output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            last_srv  <= 1'b1;
            f_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            f_ack     <= 1'b0;
            d_ack     <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            last_srv  <= last_srv_nx;
            f_gnt     <= f_gnt_nx;
            d_gnt     <= d_gnt_nx;
            f_ack     <= f_ack_nx;
            d_ack     <= d_ack_nx;
            rdata     <= rdata_nx;
            busy      <= busy_nx;
            mem_en    <= mem_en_nx;
            mem_rw    <= mem_rw_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        last_srv_nx  = last_srv;
        pick_d       = 1'b0;
        f_gnt_nx     = f_gnt;
        d_gnt_nx     = d_gnt;
        rdata_nx     = rdata;
        mem_rw_nx    = mem_rw;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;

        case (state)
            S_IDLE: begin
                if (f_req || d_req) begin
                    // D wins only when alone or when F was served last
                    pick_d      = d_req && (!f_req || !last_srv);
                    state_nx    = S_LATCH;
                    last_srv_nx = pick_d;
                    f_gnt_nx    = !pick_d;
                    d_gnt_nx    = pick_d;
                    if (pick_d) begin
                        mem_addr_nx  = d_addr;
                        mem_rw_nx    = d_rw;
                        mem_wdata_nx = d_wdata;
                    end else begin
                        mem_addr_nx  = f_addr;
                        mem_rw_nx    = 1'b0;
                    end
                end
            end
            S_LATCH: begin
                state_nx = S_ACCESS;
                cnt_nx   = CNT_W'(MEM_LAT - 1);
            end
            S_ACCESS: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_W'(1);
                end else begin
                    state_nx = S_DONE;
                    if (!mem_rw) begin
                        rdata_nx = mem_rdata;
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                f_gnt_nx = 1'b0;
                d_gnt_nx = 1'b0;
            end
            default: begin
                state_nx = S_IDLE;
                f_gnt_nx = 1'b0;
                d_gnt_nx = 1'b0;
            end
        endcase

        busy_nx   = (state_nx != S_IDLE);
        mem_en_nx = (state_nx == S_ACCESS);
        f_ack_nx  = (state_nx == S_DONE) && f_gnt_nx;
        d_ack_nx  = (state_nx == S_DONE) && d_gnt_nx;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: MEM_LAT=2 main instance
// plus MEM_LAT=1 and MEM_LAT=5 instances for latency checks.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, d_req, d_rw;
    logic [7:0]  f_addr, d_addr;
    logic [15:0] d_wdata, mem_rdata;
    logic        f_gnt, d_gnt, f_ack, d_ack, busy, mem_en, mem_rw;
    logic [15:0] rdata, mem_wdata;
    logic [7:0]  mem_addr;

    logic        lf_req;
    logic        l1_f_gnt, l1_d_gnt, l1_f_ack, l1_d_ack, l1_busy, l1_mem_en, l1_mem_rw;
    logic [15:0] l1_rdata, l1_mem_wdata;
    logic [7:0]  l1_mem_addr;
    logic        l5_f_gnt, l5_d_gnt, l5_f_ack, l5_d_ack, l5_busy, l5_mem_en, l5_mem_rw;
    logic [15:0] l5_rdata, l5_mem_wdata;
    logic [7:0]  l5_mem_addr;

    int checks = 0;
    int failures = 0;
    int gap, overlap, fa_cnt, da_cnt, en1, en5, ack1, ack5;
    logic seen;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .f_gnt(f_gnt), .d_gnt(d_gnt), .f_ack(f_ack), .d_ack(d_ack),
        .rdata(rdata), .busy(busy), .mem_en(mem_en), .mem_rw(mem_rw),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .f_req(lf_req), .f_addr(8'h44),
        .d_req(1'b0), .d_rw(1'b0), .d_addr(8'h00), .d_wdata(16'h0000),
        .f_gnt(l1_f_gnt), .d_gnt(l1_d_gnt), .f_ack(l1_f_ack), .d_ack(l1_d_ack),
        .rdata(l1_rdata), .busy(l1_busy), .mem_en(l1_mem_en), .mem_rw(l1_mem_rw),
        .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(5)) u_lat5 (
        .clk(clk), .rst(rst),
        .f_req(lf_req), .f_addr(8'h55),
        .d_req(1'b0), .d_rw(1'b0), .d_addr(8'h00), .d_wdata(16'h0000),
        .f_gnt(l5_f_gnt), .d_gnt(l5_d_gnt), .f_ack(l5_f_ack), .d_ack(l5_d_ack),
        .rdata(l5_rdata), .busy(l5_busy), .mem_en(l5_mem_en), .mem_rw(l5_mem_rw),
        .mem_addr(l5_mem_addr), .mem_wdata(l5_mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; observe/drive 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        f_req = 1'b0; d_req = 1'b0; d_rw = 1'b0; lf_req = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;

        check("rst_f_gnt", 32'(f_gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);

        // Single fetch; cycle 0 is this IDLE cycle
        f_req = 1'b1; f_addr = 8'h10; mem_rdata = 16'hDEAD;
        tick();
        check("f1_gnt", 32'({f_gnt, d_gnt}), 32'b10);
        check("f1_latch_en", 32'(mem_en), 32'd0);
        check("f1_addr", 32'(mem_addr), 32'h10);
        tick();
        check("f1_en_c2", 32'({mem_en, mem_rw}), 32'b10);
        tick();
        check("f1_en_c3", 32'(mem_en), 32'd1);
        mem_rdata = 16'hBEEF;
        tick();
        check("f1_ack", 32'({f_ack, d_ack, f_gnt, mem_en}), 32'b1010);
        check("f1_rdata", 32'(rdata), 32'hBEEF);
        f_req = 1'b0;
        tick();
        check("f1_idle", 32'({busy, f_ack, f_gnt}), 32'd0);

        // Store; changing inputs after the latch edge must have no effect
        d_req = 1'b1; d_rw = 1'b1; d_addr = 8'h3F; d_wdata = 16'h1234; mem_rdata = 16'h5555;
        tick();
        check("st_gnt", 32'({f_gnt, d_gnt}), 32'b01);
        d_addr = 8'hAA; d_wdata = 16'hFFFF; d_rw = 1'b0;
        tick();
        check("st_access", 32'({mem_en, mem_rw}), 32'b11);
        check("st_addr", 32'(mem_addr), 32'h3F);
        check("st_wdata", 32'(mem_wdata), 32'h1234);
        tick(); tick();
        check("st_ack", 32'({f_ack, d_ack}), 32'b01);
        check("st_rdata_held", 32'(rdata), 32'hBEEF);
        d_req = 1'b0;
        tick();

        // Both requesting continuously: F served first, then alternating
        f_req = 1'b1; d_req = 1'b1; d_rw = 1'b0; f_addr = 8'h01; d_addr = 8'h02;
        mem_rdata = 16'h0A0A;
        overlap = 0;
        for (int n = 0; n < 4; n++) begin
            gap = 0;
            seen = 1'b0;
            for (int c = 0; c < 12 && !seen; c++) begin
                tick();
                gap++;
                if (f_gnt && d_gnt) overlap = 1;
                if (f_ack || d_ack) seen = 1'b1;
            end
            check("rr_seen", 32'(seen), 32'd1);
            check("rr_order", 32'({f_ack, d_ack}), (n % 2 == 0) ? 32'b10 : 32'b01);
            check("rr_gap", 32'(gap), (n == 0) ? 32'd4 : 32'd5);
            check("rr_rdata", 32'(rdata), 32'h0A0A);
        end
        check("rr_no_overlap", 32'(overlap), 32'd0);
        f_req = 1'b0; d_req = 1'b0;
        tick();

        // Load whose request drops during LATCH still completes once
        d_req = 1'b1; d_rw = 1'b0; d_addr = 8'h77; mem_rdata = 16'h7777;
        tick();
        check("drop_gnt", 32'(d_gnt), 32'd1);
        d_req = 1'b0;
        fa_cnt = 0; da_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (f_ack) fa_cnt++;
            if (d_ack) da_cnt++;
        end
        check("drop_d_acks", 32'(da_cnt), 32'd1);
        check("drop_f_acks", 32'(fa_cnt), 32'd0);
        check("drop_rdata", 32'(rdata), 32'h7777);

        // Reset in the first ACCESS cycle
        f_req = 1'b1; f_addr = 8'h22;
        tick(); tick();
        check("rst_mid_en", 32'(mem_en), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_outs", 32'({f_gnt, d_gnt, f_ack, d_ack, busy, mem_en, mem_rw}), 32'd0);
        check("rst_mid_addr", 32'(mem_addr), 32'd0);
        check("rst_mid_rdata", 32'(rdata), 32'd0);
        f_req = 1'b0;
        fa_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (f_ack || d_ack) fa_cnt++;
        end
        check("rst_mid_no_ack", 32'(fa_cnt), 32'd0);
        rst = 1'b0;
        f_req = 1'b1; d_req = 1'b1; d_rw = 1'b0; f_addr = 8'h33;
        tick();
        check("post_rst_gnt", 32'({f_gnt, d_gnt}), 32'b10);
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            tick();
            if (f_ack || d_ack) seen = 1'b1;
        end
        check("post_rst_ack", 32'({seen, f_ack, d_ack}), 32'b110);
        check("post_rst_rdata", 32'(rdata), 32'h7777);
        f_req = 1'b0; d_req = 1'b0;
        tick(); tick();

        // MEM_LAT=1 and MEM_LAT=5 builds; cycle numbering from the request edge
        lf_req = 1'b1; mem_rdata = 16'hC0DE;
        en1 = 0; en5 = 0; ack1 = 0; ack5 = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (l1_mem_en) en1++;
            if (l5_mem_en) en5++;
            if (l1_f_ack) begin
                ack1 = k;
                lf_req = 1'b0;
            end
            if (l5_f_ack) ack5 = k;
        end
        check("lat1_en_cycles", 32'(en1), 32'd1);
        check("lat1_ack_cycle", 32'(ack1), 32'd3);
        check("lat5_en_cycles", 32'(en5), 32'd5);
        check("lat5_ack_cycle", 32'(ack5), 32'd7);
        check("lat_rdata", 32'({l1_rdata, l5_rdata}), 32'hC0DEC0DE);
        check("lat_idle", 32'({l1_busy, l5_busy}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
